hazard_info_pipe: RTL and testbench

Carries the per-instruction hazard info bundle and PC from Decode through Execute, Memory and Writeback. Each bundle holds source registers, destination register, use times and produce times. On each advance, the produce-time (tnew) is aged by one. A stall inserts a bubble into E. The block supplies the registered infoE/infoM bundles consumed by the stall controller, and generates forwarding-mux selects for the D, E and M stages from the same registered state.

---
 rtl/hazard_info_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_hazard_info_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_info_pipe.sv
// ---------------------------------------------------------------------------
// hazard_info_pipe
//
// Purpose:
//   Carries the per-instruction hazard info bundle and PC from Decode through
//   Execute, Memory and Writeback. The produce time (tnew) ages by one on
//   each advance and saturates at zero. A stall puts a bubble into E while
//   M and W keep draining. Forwarding selects for the D, E and M stages are
//   derived combinationally from the registered E/M/W state plus infoD.
//
// Info bundle layout (INFOW = 21):
//   rs [4:0], rt [9:5], tarReg [14:10], rsuse [16:15], rtuse [18:17],
//   tnew [20:19]
//
// Ports:
//   clk                  system clock, rising edge
//   reset                synchronous active-high clear of all pipeline state
//   stall                1 = bubble into E this edge (D is held upstream)
//   infoD, pcD           bundle and PC of the instruction in D
//   infoE/M/W, pcE/M/W   registered bundles and PCs of E, M, W
//   validE/M/W           stage holds a real instruction
//   fwdRsD, fwdRtD       D source select: 0 regfile, 1 E, 2 M, 3 W
//   fwdRsE, fwdRtE       E source select: 0 pipeline, 2 M, 3 W
//   fwdRtM               M store data select: 0 pipeline, 1 W
// ---------------------------------------------------------------------------
module hazard_info_pipe #(
    parameter int INFOW = 21,
    parameter int PCW   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [INFOW-1:0] infoD,
    input  logic [PCW-1:0]   pcD,
    output logic [INFOW-1:0] infoE,
    output logic [INFOW-1:0] infoM,
    output logic [INFOW-1:0] infoW,
    output logic [PCW-1:0]   pcE,
    output logic [PCW-1:0]   pcM,
    output logic [PCW-1:0]   pcW,
    output logic             validE,
    output logic             validM,
    output logic             validW,
    output logic [1:0]       fwdRsD,
    output logic [1:0]       fwdRtD,
    output logic [1:0]       fwdRsE,
    output logic [1:0]       fwdRtE,
    output logic             fwdRtM
);

    // Field positions inside the info bundle.
    localparam int RS_LO   = 0;
    localparam int RS_HI   = 4;
    localparam int RT_LO   = 5;
    localparam int RT_HI   = 9;
    localparam int TAR_LO  = 10;
    localparam int TAR_HI  = 14;
    localparam int TNEW_LO = 19;
    localparam int TNEW_HI = 20;

    // Forwarding select encodings.
    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_E    = 2'd1;
    localparam logic [1:0] SEL_M    = 2'd2;
    localparam logic [1:0] SEL_W    = 2'd3;

    // Pipeline registers and their next-state values.
    logic [INFOW-1:0] infoE_q, infoE_d;
    logic [INFOW-1:0] infoM_q, infoM_d;
    logic [INFOW-1:0] infoW_q, infoW_d;
    logic [PCW-1:0]   pcE_q, pcE_d;
    logic [PCW-1:0]   pcM_q, pcM_d;
    logic [PCW-1:0]   pcW_q, pcW_d;
    logic             validE_q, validE_d;
    logic             validM_q, validM_d;
    logic             validW_q, validW_d;

    // Returns the bundle with its tnew field reduced by one, stopping at zero
    // so that a finished producer never wraps around to look busy again.
    function automatic logic [INFOW-1:0] ageInfo(input logic [INFOW-1:0] info);
        logic [INFOW-1:0] aged;
        logic [1:0]       t;
        aged = info;
        t    = info[TNEW_HI:TNEW_LO];
        if (t != 2'd0) begin
            aged[TNEW_HI:TNEW_LO] = t - 2'd1;
        end
        return aged;
    endfunction

    // A stage matches register r when it holds a real instruction that
    // writes r, and r is not the hard-wired zero register.
    function automatic logic stageMatches(input logic             valid,
                                          input logic [INFOW-1:0] info,
                                          input logic [4:0]       r);
        return valid && (info[TAR_HI:TAR_LO] == r) && (r != 5'd0);
    endfunction

    // A matching stage can only supply the value once its result exists.
    function automatic logic stageReady(input logic [INFOW-1:0] info);
        return info[TNEW_HI:TNEW_LO] == 2'd0;
    endfunction

    // D-stage select. The nearest matching stage decides the outcome; if it
    // is not ready yet the select is 0 rather than falling through to an
    // older stage that holds a stale value of the same register.
    function automatic logic [1:0] selectD(input logic [4:0]       r,
                                           input logic             vE,
                                           input logic [INFOW-1:0] iE,
                                           input logic             vM,
                                           input logic [INFOW-1:0] iM,
                                           input logic             vW,
                                           input logic [INFOW-1:0] iW);
        logic [1:0] sel;
        sel = SEL_NONE;
        if (stageMatches(vE, iE, r)) begin
            sel = stageReady(iE) ? SEL_E : SEL_NONE;
        end else if (stageMatches(vM, iM, r)) begin
            sel = stageReady(iM) ? SEL_M : SEL_NONE;
        end else if (stageMatches(vW, iW, r)) begin
            sel = stageReady(iW) ? SEL_W : SEL_NONE;
        end
        return sel;
    endfunction

    // E-stage select: same nearest-match rule, looking only at M and W.
    function automatic logic [1:0] selectE(input logic [4:0]       r,
                                           input logic             vM,
                                           input logic [INFOW-1:0] iM,
                                           input logic             vW,
                                           input logic [INFOW-1:0] iW);
        logic [1:0] sel;
        sel = SEL_NONE;
        if (stageMatches(vM, iM, r)) begin
            sel = stageReady(iM) ? SEL_M : SEL_NONE;
        end else if (stageMatches(vW, iW, r)) begin
            sel = stageReady(iW) ? SEL_W : SEL_NONE;
        end
        return sel;
    endfunction

    // Next-state logic for the three stages. E either takes the D
    // instruction or a zeroed bubble when stalled; M and W always shift
    // forward with tnew aged by one so the stall never freezes them.
    always_comb begin
        infoE_d  = infoD;
        pcE_d    = pcD;
        validE_d = 1'b1;
        if (stall) begin
            infoE_d  = '0;
            pcE_d    = '0;
            validE_d = 1'b0;
        end

        infoM_d  = ageInfo(infoE_q);
        pcM_d    = pcE_q;
        validM_d = validE_q;

        infoW_d  = ageInfo(infoM_q);
        pcW_d    = pcM_q;
        validW_d = validM_q;
    end

    // State register. Reset wins over stall and empties every stage in a
    // single edge, discarding whatever was in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            infoE_q  <= '0;
            infoM_q  <= '0;
            infoW_q  <= '0;
            pcE_q    <= '0;
            pcM_q    <= '0;
            pcW_q    <= '0;
            validE_q <= 1'b0;
            validM_q <= 1'b0;
            validW_q <= 1'b0;
        end else begin
            infoE_q  <= infoE_d;
            infoM_q  <= infoM_d;
            infoW_q  <= infoW_d;
            pcE_q    <= pcE_d;
            pcM_q    <= pcM_d;
            pcW_q    <= pcW_d;
            validE_q <= validE_d;
            validM_q <= validM_d;
            validW_q <= validW_d;
        end
    end

    // Forwarding selects come straight from registered state plus infoD,
    // so there is no path from stall into any of them.
    always_comb begin
        fwdRsD = selectD(infoD[RS_HI:RS_LO], validE_q, infoE_q,
                         validM_q, infoM_q, validW_q, infoW_q);
        fwdRtD = selectD(infoD[RT_HI:RT_LO], validE_q, infoE_q,
                         validM_q, infoM_q, validW_q, infoW_q);
        fwdRsE = selectE(infoE_q[RS_HI:RS_LO], validM_q, infoM_q,
                         validW_q, infoW_q);
        fwdRtE = selectE(infoE_q[RT_HI:RT_LO], validM_q, infoM_q,
                         validW_q, infoW_q);
        fwdRtM = stageMatches(validW_q, infoW_q, infoM_q[RT_HI:RT_LO])
                 && stageReady(infoW_q);
    end

    assign infoE  = infoE_q;
    assign infoM  = infoM_q;
    assign infoW  = infoW_q;
    assign pcE    = pcE_q;
    assign pcM    = pcM_q;
    assign pcW    = pcW_q;
    assign validE = validE_q;
    assign validM = validM_q;
    assign validW = validW_q;

endmodule

// File: tb/tb_hazard_info_pipe.sv
// ---------------------------------------------------------------------------
// tb_hazard_info_pipe
//
// Purpose:
//   Drives hazard_info_pipe with directed scenarios followed by random
//   traffic. A reference model keeps the history of what entered E on each
//   edge; stage k holds the instruction issued k edges ago, with tnew
//   reduced by k and clamped at zero. Expected outputs are queued when
//   stimulus is applied and popped by an independent monitor.
// ---------------------------------------------------------------------------
module tb_hazard_info_pipe;

    localparam int INFOW = 21;
    localparam int PCW   = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic [INFOW-1:0] infoD;
    logic [PCW-1:0]   pcD;
    logic [INFOW-1:0] infoE, infoM, infoW;
    logic [PCW-1:0]   pcE, pcM, pcW;
    logic             validE, validM, validW;
    logic [1:0]       fwdRsD, fwdRtD, fwdRsE, fwdRtE;
    logic             fwdRtM;

    always #5 clk = ~clk;

    hazard_info_pipe #(.INFOW(INFOW), .PCW(PCW)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .infoD(infoD), .pcD(pcD),
        .infoE(infoE), .infoM(infoM), .infoW(infoW),
        .pcE(pcE), .pcM(pcM), .pcW(pcW),
        .validE(validE), .validM(validM), .validW(validW),
        .fwdRsD(fwdRsD), .fwdRtD(fwdRtD),
        .fwdRsE(fwdRsE), .fwdRtE(fwdRtE),
        .fwdRtM(fwdRtM)
    );

    typedef struct {
        logic             v;
        logic [INFOW-1:0] info;
        logic [PCW-1:0]   pc;
    } stage_t;

    typedef struct {
        logic [INFOW-1:0] infoE, infoM, infoW;
        logic [PCW-1:0]   pcE, pcM, pcW;
        logic             vE, vM, vW;
        logic [1:0]       rsD, rtD, rsE, rtE;
        logic             rtM;
    } exp_t;

    exp_t   expQ[$];
    stage_t hist[$];   // hist[0] = E, hist[1] = M, hist[2] = W
    int     total = 0;
    int     bad   = 0;

    // Shared comparison routine; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [INFOW-1:0] mkInfo(input int rs, input int rt,
                                                input int tar, input int rsuse,
                                                input int rtuse, input int tnew);
        logic [INFOW-1:0] x;
        x = {tnew[1:0], rtuse[1:0], rsuse[1:0], tar[4:0], rt[4:0], rs[4:0]};
        return x;
    endfunction

    function automatic stage_t bubble();
        stage_t b;
        b.v    = 1'b0;
        b.info = '0;
        b.pc   = '0;
        return b;
    endfunction

    // Bundle as seen in a stage 'age' edges after entering E.
    function automatic logic [INFOW-1:0] agedInfo(input stage_t s, input int age);
        logic [INFOW-1:0] x;
        int t;
        x = s.info;
        t = int'(s.info[20:19]) - age;
        if (t < 0) t = 0;
        x[20:19] = t[1:0];
        return x;
    endfunction

    // Nearest stage (starting at 'first') writing r decides; it supplies
    // only if its aged tnew is zero.
    function automatic logic [1:0] modelSel(input logic [4:0] r, input int first);
        logic [INFOW-1:0] a;
        for (int k = first; k < 3; k++) begin
            if (hist[k].v && hist[k].info[14:10] == r && r != 5'd0) begin
                a = agedInfo(hist[k], k);
                return (a[20:19] == 2'd0) ? 2'(k + 1) : 2'd0;
            end
        end
        return 2'd0;
    endfunction

    // Drives one cycle of inputs at the falling edge, advances the model
    // to the state after the following rising edge and queues what the
    // DUT should show then.
    task automatic applyStimulus(input logic rst, input logic stl,
                                 input logic [INFOW-1:0] info,
                                 input logic [PCW-1:0] pc);
        stage_t n;
        exp_t   e;
        logic [INFOW-1:0] mInfo;
        @(negedge clk);
        reset = rst;
        stall = stl;
        infoD = info;
        pcD   = pc;
        if (rst) begin
            hist = {};
            repeat (3) hist.push_back(bubble());
        end else begin
            if (stl) n = bubble();
            else begin
                n.v = 1'b1; n.info = info; n.pc = pc;
            end
            hist.push_front(n);
            void'(hist.pop_back());
        end
        e.infoE = agedInfo(hist[0], 0);
        e.infoM = agedInfo(hist[1], 1);
        e.infoW = agedInfo(hist[2], 2);
        e.pcE = hist[0].pc; e.pcM = hist[1].pc; e.pcW = hist[2].pc;
        e.vE  = hist[0].v;  e.vM  = hist[1].v;  e.vW  = hist[2].v;
        e.rsD = modelSel(info[4:0], 0);
        e.rtD = modelSel(info[9:5], 0);
        e.rsE = modelSel(hist[0].info[4:0], 1);
        e.rtE = modelSel(hist[0].info[9:5], 1);
        mInfo = hist[1].info;
        e.rtM = (modelSel(mInfo[9:5], 2) == 2'd3);
        expQ.push_back(e);
    endtask

    // Monitor: one expected record per rising edge, sampled 1 unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("sb_infoE", 32'(infoE), 32'(e.infoE));
                checkOutput("sb_infoM", 32'(infoM), 32'(e.infoM));
                checkOutput("sb_infoW", 32'(infoW), 32'(e.infoW));
                checkOutput("sb_pcE", pcE, e.pcE);
                checkOutput("sb_pcM", pcM, e.pcM);
                checkOutput("sb_pcW", pcW, e.pcW);
                checkOutput("sb_valid", {validE, validM, validW}, {e.vE, e.vM, e.vW});
                checkOutput("sb_fwdRsD", 32'(fwdRsD), 32'(e.rsD));
                checkOutput("sb_fwdRtD", 32'(fwdRtD), 32'(e.rtD));
                checkOutput("sb_fwdRsE", 32'(fwdRsE), 32'(e.rsE));
                checkOutput("sb_fwdRtE", 32'(fwdRtE), 32'(e.rtE));
                checkOutput("sb_fwdRtM", 32'(fwdRtM), 32'(e.rtM));
            end
        end
    end

    // Directed scenarios followed by random traffic.
    initial begin
        logic [INFOW-1:0] nop, ld, x, a, b, c, info;
        logic [PCW-1:0]   pc;
        logic             rst, stl, held;

        reset = 1'b1;
        stall = 1'b0;
        infoD = mkInfo(1, 2, 3, 0, 0, 1);
        pcD   = 32'hDEAD;
        repeat (3) hist.push_back(bubble());
        nop = mkInfo(0, 0, 0, 3, 3, 0);

        // Reset with nonzero infoD for two edges.
        applyStimulus(1, 0, mkInfo(1, 2, 3, 0, 0, 1), 32'hDEAD);
        applyStimulus(1, 0, mkInfo(1, 2, 3, 0, 0, 1), 32'hDEAD);
        @(posedge clk); #1;
        checkOutput("rst_infoE", 32'(infoE), 0);
        checkOutput("rst_pcW", pcW, 0);
        checkOutput("rst_valid", {validE, validM, validW}, 0);
        checkOutput("rst_fwdRsD", 32'(fwdRsD), 0);

        // Load ageing through E, M, W.
        ld = mkInfo(1, 2, 8, 0, 3, 2);
        applyStimulus(0, 0, ld, 32'h3000);
        @(posedge clk); #1;
        checkOutput("age_tnewE", 32'(infoE[20:19]), 2);
        applyStimulus(0, 0, nop, 32'h3004);
        @(posedge clk); #1;
        checkOutput("age_tnewM", 32'(infoM[20:19]), 1);
        applyStimulus(0, 0, nop, 32'h3008);
        @(posedge clk); #1;
        checkOutput("age_tnewW", 32'(infoW[20:19]), 0);
        checkOutput("age_pcW", pcW, 32'h3000);
        checkOutput("age_tarW", 32'(infoW[14:10]), 8);

        // tnew = 0 stays 0.
        applyStimulus(0, 0, mkInfo(1, 2, 3, 0, 0, 0), 32'h40);
        applyStimulus(0, 0, nop, 32'h44);
        @(posedge clk); #1;
        checkOutput("sat_tnewM", 32'(infoM[20:19]), 0);
        applyStimulus(0, 0, nop, 32'h48);
        @(posedge clk); #1;
        checkOutput("sat_tnewW", 32'(infoW[20:19]), 0);

        // Stall bubble behind a load.
        x = mkInfo(9, 4, 10, 0, 1, 1);
        applyStimulus(0, 0, mkInfo(1, 2, 9, 0, 0, 2), 32'h100);
        applyStimulus(0, 1, x, 32'h104);
        @(posedge clk); #1;
        checkOutput("stall_validE", 32'(validE), 0);
        checkOutput("stall_infoE", 32'(infoE), 0);
        checkOutput("stall_pcE", pcE, 0);
        checkOutput("stall_tnewM", 32'(infoM[20:19]), 1);
        checkOutput("stall_pcM", pcM, 32'h100);
        checkOutput("stall_fwdRsD", 32'(fwdRsD), 0);
        applyStimulus(0, 0, x, 32'h104);
        @(posedge clk); #1;
        checkOutput("unstall_infoE", 32'(infoE), 32'(x));
        checkOutput("unstall_pcE", pcE, 32'h104);
        checkOutput("unstall_fwdRsD", 32'(fwdRsD), 3);

        // E matches but is not ready: M must not be chosen.
        a = mkInfo(1, 2, 5, 0, 0, 1);
        b = mkInfo(3, 4, 5, 0, 0, 1);
        c = mkInfo(5, 6, 7, 0, 0, 1);
        applyStimulus(0, 0, a, 32'h200);
        applyStimulus(0, 0, b, 32'h204);
        applyStimulus(0, 1, c, 32'h208);
        #1;
        checkOutput("prio_blockE", 32'(fwdRsD), 0);
        @(posedge clk); #1;
        checkOutput("prio_fromM", 32'(fwdRsD), 2);
        checkOutput("prio_rtD", 32'(fwdRtD), 0);
        applyStimulus(0, 0, c, 32'h208);

        // Register 0 is never forwarded; register 7 is.
        applyStimulus(0, 0, mkInfo(1, 2, 0, 0, 0, 0), 32'h300);
        applyStimulus(0, 0, mkInfo(1, 0, 0, 0, 0, 0), 32'h304);
        applyStimulus(0, 0, mkInfo(0, 0, 0, 0, 0, 0), 32'h308);
        @(posedge clk); #1;
        checkOutput("zero_fwdRtM", 32'(fwdRtM), 0);
        checkOutput("zero_fwdRtD", 32'(fwdRtD), 0);
        checkOutput("zero_validW", 32'(validW), 1);
        applyStimulus(0, 0, mkInfo(1, 2, 7, 0, 0, 0), 32'h400);
        applyStimulus(0, 0, mkInfo(1, 7, 0, 0, 0, 0), 32'h404);
        applyStimulus(0, 0, mkInfo(0, 7, 0, 0, 0, 0), 32'h408);
        @(posedge clk); #1;
        checkOutput("r7_fwdRtM", 32'(fwdRtM), 1);
        checkOutput("r7_fwdRtD", 32'(fwdRtD), 3);
        checkOutput("r7_fwdRtE", 32'(fwdRtE), 3);

        // Random traffic: small register range for frequent hazards, held
        // D while stalled, occasional mid-stream reset.
        held = 1'b0;
        info = nop;
        pc   = '0;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            stl = ($urandom_range(0, 3) == 0);
            if (!held) begin
                info = mkInfo($urandom_range(0, 7), $urandom_range(0, 7),
                              $urandom_range(0, 7), $urandom_range(0, 3),
                              $urandom_range(0, 3), $urandom_range(0, 3));
                pc = $urandom;
            end
            applyStimulus(rst, stl, info, pc);
            held = stl && !rst;
        end

        // Let the monitor drain, bounded.
        for (int w = 0; w < 10 && expQ.size() > 0; w++) @(posedge clk);
        #2;
        checkOutput("drain", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
